sample_walk_ctrl: RTL and testbench
===================================

# sample_walk_ctrl

Sample-walk controller that sequences the bounding-box stage. It accepts one clipped, valid triangle and bounding box at a time from bbox (R13) and walks every subsample point inside the box in raster order, emitting one candidate sample per accepted handshake to the sample-test stage (R14). It drives the bbox stage's `halt_RnnnnL` so bbox holds its pipeline while a triangle's walk is in progress.

## Interface
- SIGFIG, 24, bits in position and color fixed-point values
- RADIX, 10, fraction bits; must be ≥ 3
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- tri_R13S  in  signed SIGFIG [VERTS][AXIS]  triangle from bbox
- color_R13U  in  SIGFIG [COLORS]  triangle color from bbox
- box_R13S  in  signed SIGFIG [2][2]  [0]=LL, [1]=UR; [.][0]=x, [.][1]=y; already floored to the grid and clipped
- validTri_R13H  in  1  bbox output is valid
- subSample_RnnnnU  in  4  one-hot MSAA code: 1000=1x, 0100=4x, 0010=16x, 0001=64x
- ready_R14H  in  1  downstream accepts the current sample
- halt_RnnnnL  out  1  to bbox `halt_RnnnnL`; 1 = bbox may advance, 0 = bbox holds
- tri_R14S  out  signed SIGFIG [VERTS][AXIS]  latched triangle
- color_R14U  out  SIGFIG [COLORS]  latched color
- sample_R14S  out  signed SIGFIG [2]  current sample x,y
- validSamp_R14H  out  1  sample_R14S/tri_R14S/color_R14U are valid

## Operation
- Two-state FSM, WAIT and WALK. Reset state is WAIT.
- `halt_RnnnnL` = (state == WAIT). It is decoded from registered state only, with no input-to-output combinational path.
- `validSamp_R14H` = (state == WALK).
- WAIT behavior:
  - If `validTri_R13H`=1, latch tri, color, box, and step.
  - Load `sample_R14S` = box LL.
  - Go to WALK.
  - Otherwise stay in WAIT and hold all data registers.
- Step = `{subSample_RnnnnU, (RADIX-3)'b0}` zero-extended to SIGFIG. For RADIX=10 this gives 1024/512/256/128.
  - Step is latched at triangle acceptance. Later changes to subSample do not affect the current walk.
- WALK with `ready_R14H`=0: hold all outputs stable.
- WALK with `ready_R14H`=1, advance the walk:
  - nx = x + step, computed signed in SIGFIG+1 bits.
  - If nx ≤ URx: x ← nx, and y is unchanged.
  - Else if y + step ≤ URy (SIGFIG+1 bits): x ← LLx, y ← y + step.
  - Else the last sample was accepted: go to WAIT. Sample registers hold their values.
- Degenerate box (LL == UR) produces exactly one sample.
- Data outputs are meaningful only while `validSamp_R14H`=1. Outside that, they hold their last values.
- Reset, including mid-walk: immediately go to WAIT and clear all data outputs to 0. `halt_RnnnnL`=1 and `validSamp_R14H`=0. Any partial walk is discarded.

## Timing
- Reset values: `halt_RnnnnL`=1, `validSamp_R14H`=0, `sample_R14S`/`tri_R14S`/`color_R14U`=0.
- Acceptance latency: `validTri_R13H`=1 sampled in WAIT at edge N gives `validSamp_R14H`=1 and `sample_R14S`=LL in cycle N+1. `halt_RnnnnL` is 0 from N+1.
- bbox advances at edge N because `halt_RnnnnL`=1 during the accept cycle. The next bbox output is therefore present and held during the walk.
- Throughput: one sample per cycle while `ready_R14H`=1.
- A box of W×H grid points with `ready_R14H` always high keeps `validSamp_R14H` high for exactly W·H cycles. `halt_RnnnnL` returns to 1 in the following cycle.
- One WAIT cycle is mandatory between triangles, so back-to-back triangles have a 1-cycle bubble.
- `ready_R14H` may toggle freely. Valid and data never change while valid=1 and ready=0.

## Test plan
- Reset: assert rst mid-cycle with no clock edge -> outputs zero, `halt_RnnnnL`=1, `validSamp_R14H`=0 immediately.
- 1x MSAA, LL=(0,0), UR=(2048,1024), ready=1 -> samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles.
  - `halt_RnnnnL` is low for exactly those 6 cycles.
- 4x MSAA, LL=(512,512), UR=(1024,1024) -> 4 samples: (512,512),(1024,512),(512,1024),(1024,1024).
  - Change subSample to 0001 during the walk -> sequence unchanged.
- Backpressure, same box as the 1x case: hold ready=0 for 3 cycles while sample (1024,0) is presented -> (1024,0) held for 4 cycles, same 6-sample sequence overall, 9 valid cycles total.
- Degenerate box LL=UR=(3072,2048), 16x -> exactly one sample (3072,2048), then WAIT.
  - A second valid triangle presented next is accepted after a 1-cycle bubble.
- Reset asserted during the 3rd sample of the 1x case -> walk aborts.
  - After deassertion, the next valid triangle starts at its LL with correct tri/color.

Source files
------------

// File: rtl/sample_walk_ctrl_if.sv
// Bundle of the bbox-side (R13) and sample-test-side (R14) signals around the
// sample-walk controller; slave is the controller's view, master the environment's.
interface sample_walk_ctrl_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S   [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     ready_R14H;
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, ready_R14H,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, ready_R14H,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_walk_ctrl.sv
// Walks every subsample point of one bounding box in raster order, one sample
// per accepted handshake, holding the bbox stage off while a walk is in progress.
module sample_walk_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input logic              clk,
  input logic              rst,
  sample_walk_ctrl_if.slave bus
);

  typedef enum logic {WAIT, WALK} state_t;

  state_t state, state_next;

  logic        [SIGFIG-1:0] step;
  logic        [SIGFIG-1:0] step_new;
  logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y;
  logic signed [SIGFIG:0]   nx, ny, ur_x_ext, ur_y_ext;
  logic                     step_x, step_y;

  // One-hot subsample code scaled so the 1x step is exactly one pixel.
  assign step_new = SIGFIG'(bus.subSample_RnnnnU) << (RADIX - 3);

  assign bus.halt_RnnnnL    = (state == WAIT);
  assign bus.validSamp_R14H = (state == WALK);

  always_comb begin
    nx       = {bus.sample_R14S[0][SIGFIG-1], bus.sample_R14S[0]} + {1'b0, step};
    ny       = {bus.sample_R14S[1][SIGFIG-1], bus.sample_R14S[1]} + {1'b0, step};
    ur_x_ext = {ur_x[SIGFIG-1], ur_x};
    ur_y_ext = {ur_y[SIGFIG-1], ur_y};
    step_x   = (nx <= ur_x_ext);
    step_y   = !step_x && (ny <= ur_y_ext);
    state_next = state;
    case (state)
      WAIT: if (bus.validTri_R13H) state_next = WALK;
      WALK: if (bus.ready_R14H && !step_x && !step_y) state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tri_R14S    <= '{default: '0};
      bus.color_R14U  <= '{default: '0};
      bus.sample_R14S <= '{default: '0};
      step            <= '0;
      ll_x            <= '0;
      ur_x            <= '0;
      ur_y            <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (bus.validTri_R13H) begin
            bus.tri_R14S       <= bus.tri_R13S;
            bus.color_R14U     <= bus.color_R13U;
            bus.sample_R14S[0] <= bus.box_R13S[0][0];
            bus.sample_R14S[1] <= bus.box_R13S[0][1];
            ll_x               <= bus.box_R13S[0][0];
            ur_x               <= bus.box_R13S[1][0];
            ur_y               <= bus.box_R13S[1][1];
            step               <= step_new;
          end
        end
        WALK: begin
          // On the final sample neither branch fires, so the sample holds.
          if (bus.ready_R14H) begin
            if (step_x) begin
              bus.sample_R14S[0] <= nx[SIGFIG-1:0];
            end else if (step_y) begin
              bus.sample_R14S[0] <= ll_x;
              bus.sample_R14S[1] <= ny[SIGFIG-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_walk_ctrl.sv
// Directed bench for sample_walk_ctrl: hand-computed raster sequences,
// backpressure, degenerate box, back-to-back triangles and async reset.
module tb_sample_walk_ctrl;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sample_walk_ctrl_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) ifc ();

  sample_walk_ctrl #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ex[$];
  int ey[$];

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int tri_val(input int base, input int i, input int j);
    int v;
    v = base + i * AXIS + j;
    return ((i + j) % 2 == 1) ? -v : v;
  endfunction

  function automatic int color_val(input int base, input int k);
    return base * 7 + k;
  endfunction

  task automatic drive_tri(input int base, input int llx, input int lly,
                           input int urx, input int ury);
    for (int i = 0; i < VERTS; i++)
      for (int j = 0; j < AXIS; j++)
        ifc.tri_R13S[i][j] = SIGFIG'(tri_val(base, i, j));
    for (int k = 0; k < COLORS; k++) ifc.color_R13U[k] = SIGFIG'(color_val(base, k));
    ifc.box_R13S[0][0] = SIGFIG'(llx);
    ifc.box_R13S[0][1] = SIGFIG'(lly);
    ifc.box_R13S[1][0] = SIGFIG'(urx);
    ifc.box_R13S[1][1] = SIGFIG'(ury);
  endtask

  task automatic check_data(input string tag, input int base);
    for (int i = 0; i < VERTS; i++)
      for (int j = 0; j < AXIS; j++)
        check({tag, " tri"}, int'(ifc.tri_R14S[i][j]), tri_val(base, i, j));
    for (int k = 0; k < COLORS; k++)
      check({tag, " color"}, int'(ifc.color_R14U[k]), color_val(base, k));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " halt"}, int'(ifc.halt_RnnnnL), 1);
    check({tag, " valid"}, int'(ifc.validSamp_R14H), 0);
    check({tag, " sx"}, int'(ifc.sample_R14S[0]), 0);
    check({tag, " sy"}, int'(ifc.sample_R14S[1]), 0);
    for (int i = 0; i < VERTS; i++)
      for (int j = 0; j < AXIS; j++)
        check({tag, " tri"}, int'(ifc.tri_R14S[i][j]), 0);
    for (int k = 0; k < COLORS; k++) check({tag, " color"}, int'(ifc.color_R14U[k]), 0);
  endtask

  // Called just after a rising edge with the DUT in WAIT; returns likewise.
  task automatic walk(input string name, input int llx, input int lly, input int urx,
                      input int ury, input logic [3:0] sub, input int base,
                      input int stall_idx, input int stall_n, input int sub_chg_idx,
                      input int abort_idx);
    int idx;
    int vcyc;
    int stalls;
    idx = 0; vcyc = 0; stalls = 0;
    drive_tri(base, llx, lly, urx, ury);
    ifc.subSample_RnnnnU = sub;
    ifc.validTri_R13H    = 1'b1;
    ifc.ready_R14H       = 1'b1;
    @(negedge clk);
    check({name, " idle halt"}, int'(ifc.halt_RnnnnL), 1);
    check({name, " idle valid"}, int'(ifc.validSamp_R14H), 0);
    @(posedge clk); #1;
    ifc.validTri_R13H = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ifc.ready_R14H = !(idx == stall_idx && stalls < stall_n);
      if (idx == sub_chg_idx) ifc.subSample_RnnnnU = 4'b0001;
      @(negedge clk);
      if (c == 0) begin
        check({name, " latency"}, int'(ifc.validSamp_R14H), 1);
        check_data(name, base);
      end
      if (!ifc.validSamp_R14H) break;
      vcyc++;
      check({name, " halt low"}, int'(ifc.halt_RnnnnL), 0);
      if (idx < ex.size()) begin
        check($sformatf("%s x[%0d]", name, idx), int'(ifc.sample_R14S[0]), ex[idx]);
        check($sformatf("%s y[%0d]", name, idx), int'(ifc.sample_R14S[1]), ey[idx]);
      end else begin
        check({name, " extra sample"}, idx, ex.size());
      end
      if (idx == abort_idx) begin
        #2 rst = 1'b1;
        #1 check_zero({name, " async rst"});
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (ifc.ready_R14H) idx++;
      else stalls++;
      @(posedge clk); #1;
    end
    check({name, " done"}, int'(ifc.validSamp_R14H), 0);
    check({name, " halt back"}, int'(ifc.halt_RnnnnL), 1);
    check({name, " count"}, idx, ex.size());
    check({name, " valid cycles"}, vcyc, ex.size() + stall_n);
    check({name, " hold x"}, int'(ifc.sample_R14S[0]), ex[ex.size()-1]);
    check({name, " hold y"}, int'(ifc.sample_R14S[1]), ey[ey.size()-1]);
    @(posedge clk); #1;
  endtask

  initial begin
    ifc.validTri_R13H    = 1'b0;
    ifc.ready_R14H       = 1'b0;
    ifc.subSample_RnnnnU = 4'b1000;
    drive_tri(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    ex = '{0, 1024, 2048, 0, 1024, 2048};
    ey = '{0, 0, 0, 1024, 1024, 1024};
    walk("1x", 0, 0, 2048, 1024, 4'b1000, 10, -1, 0, -1, -1);

    ex = '{512, 1024, 512, 1024};
    ey = '{512, 512, 1024, 1024};
    walk("4x", 512, 512, 1024, 1024, 4'b0100, 20, -1, 0, 1, -1);

    ex = '{0, 1024, 2048, 0, 1024, 2048};
    ey = '{0, 0, 0, 1024, 1024, 1024};
    walk("bp", 0, 0, 2048, 1024, 4'b1000, 30, 1, 3, -1, -1);

    // Degenerate box followed immediately by a second triangle.
    drive_tri(50, 3072, 2048, 3072, 2048);
    ifc.subSample_RnnnnU = 4'b0010;
    ifc.validTri_R13H    = 1'b1;
    ifc.ready_R14H       = 1'b1;
    @(negedge clk);
    check("b2b idle halt", int'(ifc.halt_RnnnnL), 1);
    @(posedge clk); #1;
    drive_tri(80, 0, 0, 1024, 0);
    ifc.subSample_RnnnnU = 4'b1000;
    @(negedge clk);
    check("b2b A valid", int'(ifc.validSamp_R14H), 1);
    check("b2b A halt", int'(ifc.halt_RnnnnL), 0);
    check("b2b A x", int'(ifc.sample_R14S[0]), 3072);
    check("b2b A y", int'(ifc.sample_R14S[1]), 2048);
    check_data("b2b A", 50);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b bubble valid", int'(ifc.validSamp_R14H), 0);
    check("b2b bubble halt", int'(ifc.halt_RnnnnL), 1);
    check("b2b bubble hold x", int'(ifc.sample_R14S[0]), 3072);
    @(posedge clk); #1;
    ifc.validTri_R13H = 1'b0;
    @(negedge clk);
    check("b2b B valid", int'(ifc.validSamp_R14H), 1);
    check("b2b B x0", int'(ifc.sample_R14S[0]), 0);
    check("b2b B y0", int'(ifc.sample_R14S[1]), 0);
    check_data("b2b B", 80);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b B x1", int'(ifc.sample_R14S[0]), 1024);
    check("b2b B valid1", int'(ifc.validSamp_R14H), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b B end", int'(ifc.validSamp_R14H), 0);
    @(posedge clk); #1;

    // Reset while the third sample is presented, then a fresh triangle.
    ex = '{0, 1024, 2048, 0, 1024, 2048};
    ey = '{0, 0, 0, 1024, 1024, 1024};
    walk("abort", 0, 0, 2048, 1024, 4'b1000, 90, -1, 0, -1, 2);

    ex = '{1024, 2048};
    ey = '{1024, 1024};
    walk("post rst", 1024, 1024, 2048, 1024, 4'b1000, 120, -1, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
